// File: rtl/seq_pkg.sv
// Shared types and helpers for the instruction sequencer.
// Instruction layout: [11:9] opcode, [8:6] ra, [5:3] rb, [2:0] rc.
package seq_pkg;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned INSTR_W = 12;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned REG_W   = 3;

    localparam logic [OP_W-1:0] OP_HALT = 3'b111;

    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [OP_W-1:0] op_of(input instr_t instr);
        return instr[INSTR_W-1 -: OP_W];
    endfunction

    function automatic logic [REG_W-1:0] ra_of(input instr_t instr);
        return instr[INSTR_W-OP_W-1 -: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] rb_of(input instr_t instr);
        return instr[INSTR_W-OP_W-REG_W-1 -: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] rc_of(input instr_t instr);
        return instr[REG_W-1:0];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Host load channel and datapath issue channel of the sequencer.
//   master : sequencer side (accepts loads, drives issue)
//   slave  : host/datapath side
interface instr_sequencer_if #(
    parameter int unsigned INSTR_W = seq_pkg::INSTR_W
);
    logic               load_valid;
    logic [INSTR_W-1:0] load_instr;
    logic               load_ready;
    logic               issue_valid;
    logic [INSTR_W-1:0] issue_instr;
    logic               issue_ready;

    modport master (
        input  load_valid, load_instr, issue_ready,
        output load_ready, issue_valid, issue_instr
    );

    modport slave (
        output load_valid, load_instr, issue_ready,
        input  load_ready, issue_valid, issue_instr
    );
endinterface

// File: rtl/prog_buffer.sv
// Program storage: DEPTH x INSTR_W registers, one synchronous write port,
// one registered read port. Storage is not reset.
//   wr_en/wr_addr/wr_data : write port
//   rd_addr -> rd_data    : read data appears the cycle after rd_addr
module prog_buffer #(
    parameter  int unsigned DEPTH   = seq_pkg::DEPTH,
    parameter  int unsigned INSTR_W = seq_pkg::INSTR_W,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: host loads instructions in IDLE, start issues them in
// order to the datapath over valid/ready; HALT opcode ends the program early.
//   clk, rst_n        : clock, async active-low reset
//   bus (master)      : load channel in, issue channel out
//   clear, start      : buffer empty / run request (IDLE only)
//   busy, done, error : status (done/error are one-cycle pulses)
//   pc, prog_count    : current index, number of loaded entries
module instr_sequencer
    import seq_pkg::*;
#(
    parameter  int unsigned DEPTH   = seq_pkg::DEPTH,
    parameter  int unsigned INSTR_W = seq_pkg::INSTR_W,
    localparam int unsigned PC_W    = $clog2(DEPTH),
    localparam int unsigned CNT_W   = PC_W + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_sequencer_if.master    bus,
    input  logic                 clear,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [PC_W-1:0]      pc,
    output logic [CNT_W-1:0]     prog_count
);

    state_t             state;
    logic [PC_W-1:0]    rd_addr_c;
    logic [INSTR_W-1:0] rd_data;
    logic               load_fire_c;
    logic               issue_fire_c;
    logic               last_c;

    // start/clear take priority over a same-cycle load
    assign load_fire_c  = (state == ST_IDLE) && bus.load_valid && bus.load_ready
                          && !clear && !start;
    assign issue_fire_c = (state == ST_ISSUE) && bus.issue_valid && bus.issue_ready;
    assign last_c       = ({1'b0, pc} == CNT_W'(prog_count - CNT_W'(1)));

    // Read address runs one cycle ahead so buffer[pc] is ready in FETCH
    always_comb begin
        rd_addr_c = pc;
        if (state == ST_IDLE) begin
            rd_addr_c = '0;
        end else if (issue_fire_c && !last_c) begin
            rd_addr_c = PC_W'(pc + PC_W'(1));
        end
    end

    prog_buffer #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (load_fire_c),
        .wr_addr (prog_count[PC_W-1:0]),
        .wr_data (bus.load_instr),
        .rd_addr (rd_addr_c),
        .rd_data (rd_data)
    );

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            pc              <= '0;
            prog_count      <= '0;
            bus.issue_valid <= 1'b0;
            bus.issue_instr <= '0;
            bus.load_ready  <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        // clear empties the buffer first, so a same-cycle start sees it empty
                        prog_count     <= '0;
                        bus.load_ready <= 1'b1;
                        if (start) begin
                            error <= 1'b1;
                        end
                    end else if (start) begin
                        if (prog_count != '0) begin
                            state          <= ST_FETCH;
                            pc             <= '0;
                            busy           <= 1'b1;
                            bus.load_ready <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end else if (load_fire_c) begin
                        prog_count     <= CNT_W'(prog_count + CNT_W'(1));
                        bus.load_ready <= (prog_count != CNT_W'(DEPTH - 1));
                    end
                end
                ST_FETCH: begin
                    if (op_of(instr_t'(rd_data)) == OP_HALT) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        bus.issue_instr <= rd_data;
                        bus.issue_valid <= 1'b1;
                        state           <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_fire_c) begin
                        bus.issue_valid <= 1'b0;
                        if (last_c) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            pc    <= PC_W'(pc + PC_W'(1));
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    state          <= ST_IDLE;
                    busy           <= 1'b0;
                    bus.load_ready <= (prog_count < CNT_W'(DEPTH));
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer. Cycle k is observed at the falling
// edge after the k-th rising edge following the start request.
module tb_instr_sequencer;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       start;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] pc;
    logic [3:0] prog_count;

    int vectors;
    int miscompares;

    logic [11:0] prog_a [4] = '{12'b000011111000, 12'b000001000001,
                                12'b101000001010, 12'b110000001011};

    instr_sequencer_if #(.INSTR_W(12)) bus ();

    instr_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .clear      (clear),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .pc         (pc),
        .prog_count (prog_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_one(input logic [11:0] instr);
        bus.load_valid = 1'b1;
        bus.load_instr = instr;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (bus.issue_valid !== 1'b0) begin miscompares++; $display("FAIL reset_issue_valid got=%b exp=0", bus.issue_valid); end
        vectors++; if (bus.issue_instr !== 12'h000) begin miscompares++; $display("FAIL reset_issue_instr got=%h exp=000", bus.issue_instr); end
        vectors++; if (bus.load_ready !== 1'b1) begin miscompares++; $display("FAIL reset_load_ready got=%b exp=1", bus.load_ready); end
        vectors++; if ({busy, done, error} !== 3'b000) begin miscompares++; $display("FAIL reset_status got=%b exp=000", {busy, done, error}); end
        vectors++; if (pc !== 3'd0) begin miscompares++; $display("FAIL reset_pc got=%0d exp=0", pc); end
        vectors++; if (prog_count !== 4'd0) begin miscompares++; $display("FAIL reset_prog_count got=%0d exp=0", prog_count); end
    endtask

    task automatic test_issue_order();
        logic exp_v, exp_d, exp_b;
        do_clear();
        for (int i = 0; i < 4; i++) load_one(prog_a[i]);
        vectors++; if (prog_count !== 4'd4) begin miscompares++; $display("FAIL order_prog_count got=%0d exp=4", prog_count); end
        bus.issue_ready = 1'b1;
        kick();
        for (int c = 1; c <= 10; c++) begin
            exp_v = (c % 2 == 0) && (c <= 8);
            exp_d = (c == 9);
            exp_b = (c <= 9);
            vectors++; if (bus.issue_valid !== exp_v) begin miscompares++; $display("FAIL order_valid cyc=%0d got=%b exp=%b", c, bus.issue_valid, exp_v); end
            if (exp_v) begin
                vectors++; if (bus.issue_instr !== prog_a[c/2-1]) begin miscompares++; $display("FAIL order_instr cyc=%0d got=%b exp=%b", c, bus.issue_instr, prog_a[c/2-1]); end
                vectors++; if (pc !== 3'(c/2-1)) begin miscompares++; $display("FAIL order_pc cyc=%0d got=%0d exp=%0d", c, pc, c/2-1); end
            end
            vectors++; if (done !== exp_d) begin miscompares++; $display("FAIL order_done cyc=%0d got=%b exp=%b", c, done, exp_d); end
            vectors++; if (busy !== exp_b) begin miscompares++; $display("FAIL order_busy cyc=%0d got=%b exp=%b", c, busy, exp_b); end
            tick();
        end
    endtask

    // Rerun of the retained program with the second instruction stalled 3 cycles
    task automatic test_stall();
        logic        exp_v, exp_d, exp_b;
        logic [11:0] exp_i;
        kick();
        for (int c = 1; c <= 13; c++) begin
            bus.issue_ready = !(c >= 4 && c <= 6);
            exp_v = (c == 2) || (c >= 4 && c <= 7) || (c == 9) || (c == 11);
            exp_i = (c == 2) ? prog_a[0] : (c <= 7) ? prog_a[1] : (c == 9) ? prog_a[2] : prog_a[3];
            exp_d = (c == 12);
            exp_b = (c <= 12);
            vectors++; if (bus.issue_valid !== exp_v) begin miscompares++; $display("FAIL stall_valid cyc=%0d got=%b exp=%b", c, bus.issue_valid, exp_v); end
            if (exp_v) begin
                vectors++; if (bus.issue_instr !== exp_i) begin miscompares++; $display("FAIL stall_instr cyc=%0d got=%b exp=%b", c, bus.issue_instr, exp_i); end
            end
            vectors++; if (done !== exp_d) begin miscompares++; $display("FAIL stall_done cyc=%0d got=%b exp=%b", c, done, exp_d); end
            vectors++; if (busy !== exp_b) begin miscompares++; $display("FAIL stall_busy cyc=%0d got=%b exp=%b", c, busy, exp_b); end
            tick();
        end
        bus.issue_ready = 1'b1;
    endtask

    task automatic test_halt();
        logic exp_v, exp_d, exp_b;
        do_clear();
        load_one(12'b000011111000);
        load_one(12'b111000000000);
        load_one(12'b101000001010);
        bus.issue_ready = 1'b1;
        kick();
        for (int c = 1; c <= 5; c++) begin
            exp_v = (c == 2);
            exp_d = (c == 4);
            exp_b = (c <= 4);
            vectors++; if (bus.issue_valid !== exp_v) begin miscompares++; $display("FAIL halt_valid cyc=%0d got=%b exp=%b", c, bus.issue_valid, exp_v); end
            if (exp_v) begin
                vectors++; if (bus.issue_instr !== 12'b000011111000) begin miscompares++; $display("FAIL halt_instr cyc=%0d got=%b exp=000011111000", c, bus.issue_instr); end
            end
            vectors++; if (done !== exp_d) begin miscompares++; $display("FAIL halt_done cyc=%0d got=%b exp=%b", c, done, exp_d); end
            vectors++; if (busy !== exp_b) begin miscompares++; $display("FAIL halt_busy cyc=%0d got=%b exp=%b", c, busy, exp_b); end
            tick();
        end
    endtask

    task automatic test_error();
        do_clear();
        kick();
        vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL err_empty_pulse got=%b exp=1", error); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL err_empty_busy got=%b exp=0", busy); end
        tick();
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL err_empty_end got=%b exp=0", error); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL err_empty_busy2 got=%b exp=0", busy); end
        load_one(prog_a[0]);
        vectors++; if (prog_count !== 4'd1) begin miscompares++; $display("FAIL err_loaded got=%0d exp=1", prog_count); end
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL err_clrstart_pulse got=%b exp=1", error); end
        vectors++; if (prog_count !== 4'd0) begin miscompares++; $display("FAIL err_clrstart_count got=%0d exp=0", prog_count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL err_clrstart_busy got=%b exp=0", busy); end
        tick();
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL err_clrstart_end got=%b exp=0", error); end
    endtask

    task automatic test_full();
        logic exp_v, exp_d, exp_b;
        do_clear();
        for (int i = 0; i < 9; i++) begin
            vectors++; if (bus.load_ready !== (i < 8)) begin miscompares++; $display("FAIL full_load_ready i=%0d got=%b exp=%b", i, bus.load_ready, (i < 8)); end
            load_one(12'(i + 1));
        end
        vectors++; if (prog_count !== 4'd8) begin miscompares++; $display("FAIL full_count got=%0d exp=8", prog_count); end
        bus.issue_ready = 1'b1;
        kick();
        for (int c = 1; c <= 18; c++) begin
            // load/clear/start while running must all be ignored
            bus.load_valid = (c == 3);
            bus.load_instr = 12'hFFF;
            clear          = (c == 3);
            start          = (c == 3);
            exp_v = (c % 2 == 0) && (c <= 16);
            exp_d = (c == 17);
            exp_b = (c <= 17);
            vectors++; if (bus.issue_valid !== exp_v) begin miscompares++; $display("FAIL full_valid cyc=%0d got=%b exp=%b", c, bus.issue_valid, exp_v); end
            if (exp_v) begin
                vectors++; if (bus.issue_instr !== 12'(c/2)) begin miscompares++; $display("FAIL full_instr cyc=%0d got=%h exp=%h", c, bus.issue_instr, 12'(c/2)); end
            end
            vectors++; if (done !== exp_d) begin miscompares++; $display("FAIL full_done cyc=%0d got=%b exp=%b", c, done, exp_d); end
            vectors++; if (busy !== exp_b) begin miscompares++; $display("FAIL full_busy cyc=%0d got=%b exp=%b", c, busy, exp_b); end
            vectors++; if (prog_count !== 4'd8) begin miscompares++; $display("FAIL full_run_count cyc=%0d got=%0d exp=8", c, prog_count); end
            vectors++; if (bus.load_ready !== 1'b0) begin miscompares++; $display("FAIL full_run_ready cyc=%0d got=%b exp=0", c, bus.load_ready); end
            tick();
        end
        bus.load_valid = 1'b0;
        clear          = 1'b0;
        start          = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        do_clear();
        load_one(prog_a[0]);
        load_one(prog_a[1]);
        bus.issue_ready = 1'b0;
        kick();
        tick();
        vectors++; if (bus.issue_valid !== 1'b1) begin miscompares++; $display("FAIL rst_pre_valid got=%b exp=1", bus.issue_valid); end
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.issue_valid !== 1'b0) begin miscompares++; $display("FAIL rst_async_valid got=%b exp=0", bus.issue_valid); end
        vectors++; if (prog_count !== 4'd0) begin miscompares++; $display("FAIL rst_async_count got=%0d exp=0", prog_count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.issue_ready = 1'b1;
        tick();
        vectors++; if (bus.load_ready !== 1'b1) begin miscompares++; $display("FAIL rst_post_ready got=%b exp=1", bus.load_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_post_busy got=%b exp=0", busy); end
        kick();
        vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL rst_post_discard got=%b exp=1", error); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_post_busy2 got=%b exp=0", busy); end
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst_n           = 1'b0;
        clear           = 1'b0;
        start           = 1'b0;
        bus.load_valid  = 1'b0;
        bus.load_instr  = '0;
        bus.issue_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_issue_order();
        test_stall();
        test_halt();
        test_error();
        test_full();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
